// File: rtl/csr_trap_ctrl_if.sv
// Interface bundle between the execute stage / CSR file and the trap sequencer.
// The master side is the pipeline + CSR file. The slave side is csr_trap_ctrl.
interface csr_trap_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Requests from the execute stage
  logic              ecall_i;
  logic              ebreak_i;
  logic              mret_i;
  logic              irq_timer_i;
  logic              irq_ext_i;
  logic [DATA_W-1:0] pc_i;
  logic              ex_csr_we_i;

  // Current CSR values
  logic [DATA_W-1:0] csr_mtvec_i;
  logic [DATA_W-1:0] csr_mepc_i;
  logic [DATA_W-1:0] csr_mstatus_i;

  // Secondary CSR write port, pipeline freeze and redirect
  logic              csr_we_o;
  logic [ADDR_W-1:0] csr_waddr_o;
  logic [DATA_W-1:0] csr_wdata_o;
  logic              hold_o;
  logic              jump_o;
  logic [DATA_W-1:0] jump_addr_o;

  modport master (
    output ecall_i, ebreak_i, mret_i, irq_timer_i, irq_ext_i, pc_i, ex_csr_we_i,
    output csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, jump_o, jump_addr_o
  );

  modport slave (
    input  ecall_i, ebreak_i, mret_i, irq_timer_i, irq_ext_i, pc_i, ex_csr_we_i,
    input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, jump_o, jump_addr_o
  );

endinterface

// File: rtl/csr_trap_ctrl.sv
// Trap sequencer: on ecall/ebreak/enabled interrupt/mret it freezes the
// pipeline, writes mepc/mcause/mstatus through the CSR file's secondary port
// (retrying any write that loses to the execute-stage port), then emits a
// single-cycle redirect to mtvec (trap) or mepc (mret).
module csr_trap_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             rst,
  csr_trap_ctrl_if.slave  bus
);

  localparam logic [11:0] MSTATUS_ADDR = 12'h300;
  localparam logic [11:0] MEPC_ADDR    = 12'h341;
  localparam logic [11:0] MCAUSE_ADDR  = 12'h342;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  localparam logic [DATA_W-1:0] CAUSE_ECALL  = DATA_W'(11);
  localparam logic [DATA_W-1:0] CAUSE_EBREAK = DATA_W'(3);
  localparam logic [DATA_W-1:0] CAUSE_TIMER  = {1'b1, (DATA_W-1)'(7)};
  localparam logic [DATA_W-1:0] CAUSE_EXT    = {1'b1, (DATA_W-1)'(11)};

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTAT,
    JUMP
  } state_t;

  typedef enum logic {
    KIND_TRAP,
    KIND_MRET
  } kind_t;

  state_t            state;
  kind_t             kind_q;
  logic [DATA_W-1:0] cause_q;
  logic [DATA_W-1:0] pc_q;

  logic              req_valid;
  kind_t             req_kind;
  logic [DATA_W-1:0] req_cause;
  logic [DATA_W-1:0] mstatus_new;

  // Pick the highest-priority request while idle. Interrupts need MIE.
  // NOTE: every signal gets a default first so this block never infers a latch.
  always_comb begin
    req_valid = 1'b0;
    req_kind  = KIND_TRAP;
    req_cause = '0;
    if (!rst && state == IDLE) begin
      if (bus.ecall_i) begin
        req_valid = 1'b1;
        req_cause = CAUSE_ECALL;
      end else if (bus.ebreak_i) begin
        req_valid = 1'b1;
        req_cause = CAUSE_EBREAK;
      end else if (bus.mret_i) begin
        req_valid = 1'b1;
        req_kind  = KIND_MRET;
      end else if (bus.irq_timer_i && bus.csr_mstatus_i[MIE_BIT]) begin
        req_valid = 1'b1;
        req_cause = CAUSE_TIMER;
      end else if (bus.irq_ext_i && bus.csr_mstatus_i[MIE_BIT]) begin
        req_valid = 1'b1;
        req_cause = CAUSE_EXT;
      end
    end
  end

  // New mstatus from the live value: trap stacks MIE into MPIE, mret unstacks it.
  always_comb begin
    mstatus_new = bus.csr_mstatus_i;
    if (kind_q == KIND_TRAP) begin
      mstatus_new[MPIE_BIT] = bus.csr_mstatus_i[MIE_BIT];
      mstatus_new[MIE_BIT]  = 1'b0;
    end else begin
      mstatus_new[MIE_BIT]  = bus.csr_mstatus_i[MPIE_BIT];
      mstatus_new[MPIE_BIT] = 1'b1;
    end
  end

  // Sequencer state and latched request; a colliding write holds its state.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      kind_q  <= KIND_TRAP;
      cause_q <= '0;
      pc_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            kind_q  <= req_kind;
            cause_q <= req_cause;
            pc_q    <= bus.pc_i;
            state   <= (req_kind == KIND_MRET) ? W_MSTAT : W_MEPC;
          end
        end
        W_MEPC:   if (!bus.ex_csr_we_i) state <= W_MCAUSE;
        W_MCAUSE: if (!bus.ex_csr_we_i) state <= W_MSTAT;
        W_MSTAT:  if (!bus.ex_csr_we_i) state <= JUMP;
        JUMP:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Output decode: writes only in W_* states, redirect only in JUMP.
  always_comb begin
    bus.csr_we_o    = 1'b0;
    bus.csr_waddr_o = '0;
    bus.csr_wdata_o = '0;
    bus.jump_o      = 1'b0;
    bus.jump_addr_o = '0;
    bus.hold_o      = req_valid || (state != IDLE);
    case (state)
      W_MEPC: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = ADDR_W'(MEPC_ADDR);
        bus.csr_wdata_o = pc_q;
      end
      W_MCAUSE: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = ADDR_W'(MCAUSE_ADDR);
        bus.csr_wdata_o = cause_q;
      end
      W_MSTAT: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = ADDR_W'(MSTATUS_ADDR);
        bus.csr_wdata_o = mstatus_new;
      end
      JUMP: begin
        bus.jump_o      = 1'b1;
        bus.jump_addr_o = (kind_q == KIND_MRET) ? bus.csr_mepc_i : bus.csr_mtvec_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed scenarios followed by
// randomized operations, compared against a write-list reference model.
module tb_csr_trap_ctrl;

  logic clk = 1'b0;
  logic rst;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_mstat;
  } wr_t;

  localparam int K_NONE = 0;
  localparam int K_TRAP = 1;
  localparam int K_MRET = 2;

  csr_trap_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  csr_trap_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Which request is taken, from the priority list and the MIE gate.
  function automatic void model_accept(input logic ec, eb, mr, ti, te,
                                       input logic [31:0] ms,
                                       output int kind, output logic [31:0] cause);
    logic mie;
    mie   = ms[3];
    kind  = K_NONE;
    cause = 32'd0;
    if (ec)             begin kind = K_TRAP; cause = 32'd11;        end
    else if (eb)        begin kind = K_TRAP; cause = 32'd3;         end
    else if (mr)        begin kind = K_MRET;                        end
    else if (ti && mie) begin kind = K_TRAP; cause = 32'h8000_0007; end
    else if (te && mie) begin kind = K_TRAP; cause = 32'h8000_000B; end
  endfunction

  // Expected mstatus value written by the sequence, using plain arithmetic.
  function automatic logic [31:0] model_mstat(input int kind, input logic [31:0] ms);
    logic [31:0] mie_v, mpie_v;
    mie_v  = (ms >> 3) & 32'd1;
    mpie_v = (ms >> 7) & 32'd1;
    if (kind == K_TRAP) model_mstat = (ms & ~32'h88) | (mie_v * 32'd128);
    else                model_mstat = (ms & ~32'h88) | 32'd128 | (mpie_v * 32'd8);
  endfunction

  task automatic clear_reqs();
    bus.ecall_i     = 1'b0;
    bus.ebreak_i    = 1'b0;
    bus.mret_i      = 1'b0;
    bus.irq_timer_i = 1'b0;
    bus.irq_ext_i   = 1'b0;
  endtask

  // Random activity on every input the sequencer must ignore or only sample live.
  task automatic noise();
    bus.ecall_i       = 1'($urandom_range(0, 1));
    bus.ebreak_i      = 1'($urandom_range(0, 1));
    bus.mret_i        = 1'($urandom_range(0, 1));
    bus.irq_timer_i   = 1'($urandom_range(0, 1));
    bus.irq_ext_i     = 1'($urandom_range(0, 1));
    bus.pc_i          = $urandom;
    bus.csr_mstatus_i = $urandom;
    bus.csr_mtvec_i   = $urandom;
    bus.csr_mepc_i    = $urandom;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE, then follow the whole sequence cycle by cycle.
  // col_idx/col_n force col_n collisions on write number col_idx; col_pct adds random ones.
  task automatic run_op(input logic ec, eb, mr, ti, te,
                        input logic [31:0] pc, ms,
                        input int col_idx, col_n, col_pct, input bit quiet);
    int          kind;
    logic [31:0] cause;
    wr_t         q[$];
    int          widx;
    int          ccnt;
    int          guard;
    logic        col;
    logic [31:0] exp_data;
    bus.ecall_i       = ec;
    bus.ebreak_i      = eb;
    bus.mret_i        = mr;
    bus.irq_timer_i   = ti;
    bus.irq_ext_i     = te;
    bus.pc_i          = pc;
    bus.csr_mstatus_i = ms;
    bus.ex_csr_we_i   = quiet ? 1'b0 : 1'($urandom_range(0, 1));
    model_accept(ec, eb, mr, ti, te, ms, kind, cause);
    @(negedge clk);
    if (kind == K_NONE) begin
      check("idle_hold", 32'(bus.hold_o), 32'd0);
      check("idle_we", 32'(bus.csr_we_o), 32'd0);
      check("idle_jump", 32'(bus.jump_o), 32'd0);
      next_cycle();
      return;
    end
    check("acc_hold", 32'(bus.hold_o), 32'd1);
    check("acc_we", 32'(bus.csr_we_o), 32'd0);
    check("acc_jump", 32'(bus.jump_o), 32'd0);
    next_cycle();

    if (kind == K_TRAP) begin
      q.push_back('{addr: 32'h341, data: pc,    is_mstat: 1'b0});
      q.push_back('{addr: 32'h342, data: cause, is_mstat: 1'b0});
    end
    q.push_back('{addr: 32'h300, data: 32'd0, is_mstat: 1'b1});

    widx  = 0;
    ccnt  = 0;
    guard = 0;
    while (q.size() > 0 && guard < 64) begin
      guard++;
      if (!quiet) noise();
      col = ((widx == col_idx) && (ccnt < col_n)) || (32'($urandom_range(0, 99)) < 32'(col_pct));
      bus.ex_csr_we_i = col;
      @(negedge clk);
      exp_data = q[0].is_mstat ? model_mstat(kind, bus.csr_mstatus_i) : q[0].data;
      check("wr_hold", 32'(bus.hold_o), 32'd1);
      check("wr_we", 32'(bus.csr_we_o), 32'd1);
      check("wr_addr", bus.csr_waddr_o, q[0].addr);
      check("wr_data", bus.csr_wdata_o, exp_data);
      check("wr_jump", 32'(bus.jump_o), 32'd0);
      next_cycle();
      if (col) ccnt++;
      else begin
        void'(q.pop_front());
        widx++;
        ccnt = 0;
      end
    end

    if (!quiet) noise();
    bus.ex_csr_we_i = quiet ? 1'b0 : 1'($urandom_range(0, 1));
    @(negedge clk);
    check("jmp_pulse", 32'(bus.jump_o), 32'd1);
    check("jmp_addr", bus.jump_addr_o, (kind == K_MRET) ? bus.csr_mepc_i : bus.csr_mtvec_i);
    check("jmp_hold", 32'(bus.hold_o), 32'd1);
    check("jmp_we", 32'(bus.csr_we_o), 32'd0);
    check("jmp_waddr", bus.csr_waddr_o, 32'd0);
    check("jmp_wdata", bus.csr_wdata_o, 32'd0);
    next_cycle();
    clear_reqs();
    bus.ex_csr_we_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    bus.pc_i          = 32'd0;
    bus.ex_csr_we_i   = 1'b0;
    bus.csr_mtvec_i   = 32'h80;
    bus.csr_mepc_i    = 32'h0;
    bus.csr_mstatus_i = 32'h0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_hold", 32'(bus.hold_o), 32'd0);
    check("rst_we", 32'(bus.csr_we_o), 32'd0);
    check("rst_waddr", bus.csr_waddr_o, 32'd0);
    check("rst_wdata", bus.csr_wdata_o, 32'd0);
    check("rst_jump", 32'(bus.jump_o), 32'd0);
    check("rst_jaddr", bus.jump_addr_o, 32'd0);
    next_cycle();
    rst = 1'b0;

    // ecall, basic trap sequence to mtvec 0x80
    bus.csr_mtvec_i = 32'h80;
    run_op(1, 0, 0, 0, 0, 32'h100, 32'h8, -1, 0, 0, 1'b1);

    // mret: single mstatus write 0x88, return to 0x104
    bus.csr_mepc_i = 32'h104;
    run_op(0, 0, 1, 0, 0, 32'h0, 32'h80, -1, 0, 0, 1'b1);

    // timer interrupt masked, then enabled
    run_op(0, 0, 0, 1, 0, 32'h200, 32'h0, -1, 0, 0, 1'b1);
    run_op(0, 0, 0, 1, 0, 32'h200, 32'h8, -1, 0, 0, 1'b1);

    // ecall wins over external irq; irq taken back-to-back afterwards
    run_op(1, 0, 0, 0, 1, 32'h300, 32'h8, -1, 0, 0, 1'b1);
    run_op(0, 0, 0, 0, 1, 32'h304, 32'h8, -1, 0, 0, 1'b1);

    // ebreak over mret
    run_op(0, 1, 1, 0, 0, 32'h400, 32'h8, -1, 0, 0, 1'b1);

    // two collision cycles on the mcause write
    run_op(1, 0, 0, 0, 0, 32'h500, 32'h8, 1, 2, 0, 1'b1);

    // reset in the middle of W_MCAUSE
    bus.ecall_i       = 1'b1;
    bus.pc_i          = 32'h600;
    bus.csr_mstatus_i = 32'h8;
    bus.ex_csr_we_i   = 1'b0;
    @(negedge clk);
    check("mr_acc_hold", 32'(bus.hold_o), 32'd1);
    next_cycle();
    bus.ecall_i = 1'b0;
    @(negedge clk);
    check("mr_mepc_addr", bus.csr_waddr_o, 32'h341);
    next_cycle();
    @(negedge clk);
    check("mr_mcause_addr", bus.csr_waddr_o, 32'h342);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_post_we", 32'(bus.csr_we_o), 32'd0);
      check("mr_post_hold", 32'(bus.hold_o), 32'd0);
      check("mr_post_waddr", bus.csr_waddr_o, 32'd0);
      check("mr_post_jump", 32'(bus.jump_o), 32'd0);
      next_cycle();
    end
    run_op(1, 0, 0, 0, 0, 32'h700, 32'h8, -1, 0, 0, 1'b1);

    // randomized operations with random collisions and input noise
    for (int n = 0; n < 60; n++) begin
      run_op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 2) == 0), $urandom, $urandom,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 25, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
